// File: rtl/button_bank_filter.sv
// N-channel active-low push-button front end: 2-flop sync, tick-gated debounce,
// and a per-channel IDLE/HELD/REPEAT tracker producing push, long and release pulses.
`timescale 1ns/1ps
module button_bank_filter #(
  parameter int CHANNELS       = 4,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int LONG_TICKS     = 200,
  parameter int REPEAT_TICKS   = 50,
  parameter int REPEAT_EN      = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] i_button_n,
  input  logic                i_sync_n,
  output logic [CHANNELS-1:0] o_btn_save,
  output logic [CHANNELS-1:0] o_btn_push,
  output logic [CHANNELS-1:0] o_btn_long,
  output logic [CHANNELS-1:0] o_btn_release,
  output logic                o_any_pressed
);

  localparam int DB_W     = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] LONG_SAT  = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

  logic [CHANNELS-1:0] sync1, sync2, raw_p;
  logic                tick;
  logic [DB_W-1:0]     db_cnt     [CHANNELS];
  logic [DB_W-1:0]     db_cnt_nxt [CHANNELS];
  logic [HOLD_W-1:0]   hold_cnt   [CHANNELS];
  logic [HOLD_W-1:0]   hold_nxt   [CHANNELS];
  state_t              state      [CHANNELS];
  state_t              state_nxt  [CHANNELS];
  logic [CHANNELS-1:0] save_nxt, push_nxt, long_nxt, rel_nxt, rise, fall;

  assign raw_p = ~sync2;
  assign tick  = ~i_sync_n;

  always_comb begin
    save_nxt   = o_btn_save;
    push_nxt   = '0;
    long_nxt   = '0;
    rel_nxt    = '0;
    rise       = '0;
    fall       = '0;
    db_cnt_nxt = db_cnt;
    hold_nxt   = hold_cnt;
    state_nxt  = state;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      if (tick) begin
        if (raw_p[ch] != o_btn_save[ch]) begin
          if (db_cnt[ch] == DB_LAST) begin
            db_cnt_nxt[ch] = '0;
            save_nxt[ch]   = raw_p[ch];
            rise[ch]       = raw_p[ch];
            fall[ch]       = ~raw_p[ch];
          end else begin
            db_cnt_nxt[ch] = db_cnt[ch] + DB_ONE;
          end
        end else begin
          db_cnt_nxt[ch] = '0;
        end
      end

      // Release is checked first so it pre-empts a long/repeat event due on the same tick.
      case (state[ch])
        IDLE: begin
          if (rise[ch]) begin
            state_nxt[ch] = HELD;
            push_nxt[ch]  = 1'b1;
            hold_nxt[ch]  = '0;
          end
        end
        HELD: begin
          if (fall[ch]) begin
            state_nxt[ch] = IDLE;
            rel_nxt[ch]   = 1'b1;
            hold_nxt[ch]  = '0;
          end else if (tick && hold_cnt[ch] != LONG_SAT) begin
            if (hold_cnt[ch] == LONG_LAST) begin
              long_nxt[ch] = 1'b1;
              if (REPEAT_EN != 0) begin
                state_nxt[ch] = REPEAT;
                hold_nxt[ch]  = '0;
              end else begin
                hold_nxt[ch] = LONG_SAT;
              end
            end else begin
              hold_nxt[ch] = hold_cnt[ch] + HOLD_ONE;
            end
          end
        end
        REPEAT: begin
          if (fall[ch]) begin
            state_nxt[ch] = IDLE;
            rel_nxt[ch]   = 1'b1;
            hold_nxt[ch]  = '0;
          end else if (tick) begin
            if (hold_cnt[ch] == REP_LAST) begin
              push_nxt[ch] = 1'b1;
              hold_nxt[ch] = '0;
            end else begin
              hold_nxt[ch] = hold_cnt[ch] + HOLD_ONE;
            end
          end
        end
        default: begin
          state_nxt[ch] = IDLE;
          hold_nxt[ch]  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1         <= '1;
      sync2         <= '1;
      o_btn_save    <= '0;
      o_btn_push    <= '0;
      o_btn_long    <= '0;
      o_btn_release <= '0;
      o_any_pressed <= 1'b0;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        db_cnt[ch]   <= '0;
        hold_cnt[ch] <= '0;
        state[ch]    <= IDLE;
      end
    end else begin
      sync1         <= i_button_n;
      sync2         <= sync1;
      o_btn_save    <= save_nxt;
      o_btn_push    <= push_nxt;
      o_btn_long    <= long_nxt;
      o_btn_release <= rel_nxt;
      o_any_pressed <= |save_nxt;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        db_cnt[ch]   <= db_cnt_nxt[ch];
        hold_cnt[ch] <= hold_nxt[ch];
        state[ch]    <= state_nxt[ch];
      end
    end
  end

endmodule
